serial_rx8: RTL



---
 rtl/serial_rx8.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/serial_rx8.sv
// Asynchronous serial byte receiver: start, 8 data bits LSB first, optional even parity, one stop.
// Define SERIAL_RX8_PARITY_EN to add the parity bit and drive ParityErr.
module serial_rx8 #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       CK,
  input  logic       Reset_n,
  input  logic       Rx,
  output logic [7:0] Data,
  output logic       Load,
  output logic       FrameErr,
  output logic       ParityErr,
  output logic       Busy
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

`ifdef SERIAL_RX8_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e            state_q, state_d;
  logic [1:0]        sync_q;
  logic              rxs;
  logic              rxs_prev_q;
  logic [CntW-1:0]   cnt_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic [7:0]        data_q;
  logic              load_q;
  logic              frame_err_q;
  logic              start_edge;
  logic              half_tick;
  logic              bit_tick;
`ifdef SERIAL_RX8_PARITY_EN
  logic              parity_bad_q;
  logic              parity_err_q;
`endif

  assign rxs        = sync_q[1];
  assign start_edge = rxs_prev_q & ~rxs;
  assign half_tick  = (cnt_q == HalfLast);
  assign bit_tick   = (cnt_q == BitLast);

  // State register
  always_ff @(posedge CK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_edge) state_d = StStart;
      StStart:  if (half_tick) state_d = rxs ? StIdle : StData;
      StData: begin
        if (bit_tick && (bit_q == 3'd7)) begin
`ifdef SERIAL_RX8_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end
      end
`ifdef SERIAL_RX8_PARITY_EN
      StParity: if (bit_tick) state_d = StStop;
`endif
      StStop:   if (bit_tick) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Synchronizer, baud counter, shift register and registered result pulses
  always_ff @(posedge CK or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q       <= 2'b11;
      rxs_prev_q   <= 1'b1;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      load_q       <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef SERIAL_RX8_PARITY_EN
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync_q      <= {sync_q[0], Rx};
      rxs_prev_q  <= rxs;
      load_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SERIAL_RX8_PARITY_EN
      parity_err_q <= 1'b0;
`endif

      // Start phase restarts at half a bit so later samples land mid-bit
      if ((state_q == StIdle) || ((state_q == StStart) && half_tick) ||
          ((state_q != StStart) && bit_tick)) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end

      if (state_q == StIdle) begin
        bit_q <= '0;
`ifdef SERIAL_RX8_PARITY_EN
        parity_bad_q <= 1'b0;
`endif
      end

      if ((state_q == StData) && bit_tick) begin
        shift_q <= {rxs, shift_q[7:1]};
        bit_q   <= bit_q + 3'd1;
      end

`ifdef SERIAL_RX8_PARITY_EN
      if ((state_q == StParity) && bit_tick) begin
        parity_bad_q <= (^shift_q) ^ rxs;
      end
`endif

      if ((state_q == StStop) && bit_tick) begin
`ifdef SERIAL_RX8_PARITY_EN
        parity_err_q <= parity_bad_q;
        if (rxs && !parity_bad_q) begin
`else
        if (rxs) begin
`endif
          data_q <= shift_q;
          load_q <= 1'b1;
        end
        frame_err_q <= ~rxs;
      end
    end
  end

  // Outputs
  always_comb begin
    Busy     = (state_q != StIdle);
    Data     = data_q;
    Load     = load_q;
    FrameErr = frame_err_q;
`ifdef SERIAL_RX8_PARITY_EN
    ParityErr = parity_err_q;
`else
    ParityErr = 1'b0;
`endif
  end

endmodule
